// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM-16 transmit path.
// Used by the symbol serializer that follows the parallel mapper.
package qam_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int QAM16_BITS_PER_SYMBOL = 4;
  localparam int DEFAULT_DATA_WIDTH_I  = 16;
  localparam int DEFAULT_DATA_WIDTH_Q  = 16;

  // Width of a symbol index within a batch; never narrower than one bit.
  function automatic int index_width(input int num_symbols);
    return (num_symbols <= 2) ? 1 : $clog2(num_symbols);
  endfunction

endpackage

// File: rtl/qam_symbol_serializer.sv
// Turns one parallel batch of QAM-16 I/Q symbols into a stream of one
// I/Q pair per cycle, with a last flag, an in-batch index and a running count.
module qam_symbol_serializer
  import qam_pkg::*;
#(
  parameter int NUM_SYMBOLS  = 4,
  parameter int DATA_WIDTH_I = DEFAULT_DATA_WIDTH_I,
  parameter int DATA_WIDTH_Q = DEFAULT_DATA_WIDTH_Q,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NUM_SYMBOLS*DATA_WIDTH_I-1:0]      in_i,
  input  logic [NUM_SYMBOLS*DATA_WIDTH_Q-1:0]      in_q,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH_I-1:0]                  out_i,
  output logic [DATA_WIDTH_Q-1:0]                  out_q,
  output logic                                     out_last,
  output logic [index_width(NUM_SYMBOLS)-1:0]      out_index,
  output logic [COUNT_WIDTH-1:0]                   sym_count
);

  localparam int IW = index_width(NUM_SYMBOLS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SYMBOLS - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Once out_valid is high, out_* hold until out_ready takes the symbol;
  // in_ready opens only when no un-emitted symbol of the current batch remains.
  state_t                  state;
  logic [DATA_WIDTH_I-1:0] hold_i [NUM_SYMBOLS];
  logic [DATA_WIDTH_Q-1:0] hold_q [NUM_SYMBOLS];
  logic [IW-1:0]           next_index;
  logic                    accept;
  logic                    emit;

  assign emit     = out_valid && out_ready;
  assign in_ready = !rst && ((state == IDLE) || (emit && out_last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    next_index = out_index + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_last  <= 1'b0;
      out_index <= '0;
      sym_count <= '0;
      for (int k = 0; k < NUM_SYMBOLS; k++) begin
        hold_i[k] <= '0;
        hold_q[k] <= '0;
      end
    end else begin
      if (emit) begin
        sym_count <= sym_count + 1'b1;
      end

      // A new batch goes straight to symbol 0 on the output registers,
      // whether it arrives from IDLE or overlaps the last-symbol transfer.
      if (accept) begin
        for (int k = 0; k < NUM_SYMBOLS; k++) begin
          hold_i[k] <= in_i[k*DATA_WIDTH_I +: DATA_WIDTH_I];
          hold_q[k] <= in_q[k*DATA_WIDTH_Q +: DATA_WIDTH_Q];
        end
        state     <= SEND;
        out_valid <= 1'b1;
        out_i     <= in_i[DATA_WIDTH_I-1:0];
        out_q     <= in_q[DATA_WIDTH_Q-1:0];
        out_index <= '0;
        out_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            out_valid <= 1'b0;
          end
          SEND: begin
            if (emit) begin
              if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end else begin
                out_index <= next_index;
                out_i     <= hold_i[next_index];
                out_q     <= hold_q[next_index];
                out_last  <= (next_index == LAST_IDX);
              end
            end
          end
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_serializer.sv
// Directed bench for qam_symbol_serializer: a default build plus a
// 4-bit counter build for the sym_count wrap.
module tb_qam_symbol_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_i;
  logic [63:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_i;
  logic [15:0] out_q;
  logic        out_last;
  logic [1:0]  out_index;
  logic [31:0] sym_count;

  logic        w_rst;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [63:0] w_in_i;
  logic [63:0] w_in_q;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_out_i;
  logic [15:0] w_out_q;
  logic        w_out_last;
  logic [1:0]  w_out_index;
  logic [3:0]  w_sym_count;

  int total = 0;
  int bad   = 0;

  qam_symbol_serializer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .out_last(out_last), .out_index(out_index), .sym_count(sym_count)
  );

  qam_symbol_serializer #(.COUNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(w_rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_i(w_in_i), .in_q(w_in_q),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_i(w_out_i), .out_q(w_out_q),
    .out_last(w_out_last), .out_index(w_out_index), .sym_count(w_sym_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Symbol tables in emission order (element k is symbol k).
  logic [15:0] t1_v [4] = '{16'h8702, 16'hD786, 16'h287A, 16'h7A1E};
  logic [15:0] a_i  [4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] a_q  [4] = '{16'h0708, 16'h0506, 16'h0304, 16'h0102};
  logic [15:0] b_i  [4] = '{16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
  logic [15:0] b_q  [4] = '{16'h4321, 16'h8765, 16'hCBA9, 16'h0FED};

  function automatic logic [63:0] pack(input logic [15:0] v [4]);
    return {v[3], v[2], v[1], v[0]};
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge, and
  // outputs are observed at that same point, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b0;
    w_rst = 1'b1; w_in_valid = 1'b0; w_in_i = '0; w_in_q = '0; w_out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_i", 32'(out_i), 0);
    chk("rst_out_q", 32'(out_q), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_sym_count", sym_count, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    w_rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 1);

    // Single batch, free-flowing output
    in_i = pack(t1_v); in_q = pack(t1_v); in_valid = 1'b1; out_ready = 1'b1;
    chk("t1_out_valid_before", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_out_valid", 32'(out_valid), 1);
      chk("t1_out_i", 32'(out_i), 32'(t1_v[k]));
      chk("t1_out_q", 32'(out_q), 32'(t1_v[k]));
      chk("t1_out_index", 32'(out_index), 32'(k));
      chk("t1_out_last", 32'(out_last), (k == 3) ? 1 : 0);
      chk("t1_in_ready", 32'(in_ready), (k == 3) ? 1 : 0);
      step();
    end
    chk("t1_done_valid", 32'(out_valid), 0);
    chk("t1_sym_count", sym_count, 4);

    // Two batches back to back
    in_i = pack(a_i); in_q = pack(a_q); in_valid = 1'b1;
    chk("b2b_in_ready_idle", 32'(in_ready), 1);
    step();
    in_i = pack(b_i); in_q = pack(b_q);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) in_valid = 1'b0;
      chk("b2b_out_valid", 32'(out_valid), 1);
      chk("b2b_out_i", 32'(out_i), (k < 4) ? 32'(a_i[k]) : 32'(b_i[k-4]));
      chk("b2b_out_q", 32'(out_q), (k < 4) ? 32'(a_q[k]) : 32'(b_q[k-4]));
      chk("b2b_out_index", 32'(out_index), 32'(k % 4));
      chk("b2b_out_last", 32'(out_last), (k % 4 == 3) ? 1 : 0);
      chk("b2b_in_ready", 32'(in_ready), (k % 4 == 3) ? 1 : 0);
      step();
    end
    chk("b2b_done_valid", 32'(out_valid), 0);
    chk("b2b_sym_count", sym_count, 12);

    // Backpressure on symbol 2, with a competing batch offered mid-batch
    in_i = pack(a_i); in_q = pack(a_q); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    in_i = pack(b_i); in_q = pack(b_q); in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_i", 32'(out_i), 32'(a_i[2]));
      chk("bp_out_q", 32'(out_q), 32'(a_q[2]));
      chk("bp_out_index", 32'(out_index), 2);
      chk("bp_out_last", 32'(out_last), 0);
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_i", 32'(out_i), 32'(a_i[2]));
    chk("bp_resume_in_ready", 32'(in_ready), 0);
    step();
    chk("bp_sym3_i", 32'(out_i), 32'(a_i[3]));
    chk("bp_sym3_last", 32'(out_last), 1);
    chk("bp_sym3_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_next_i", 32'(out_i), 32'(b_i[k]));
      chk("bp_next_q", 32'(out_q), 32'(b_q[k]));
      chk("bp_next_index", 32'(out_index), 32'(k));
      step();
    end
    chk("bp_done_valid", 32'(out_valid), 0);
    chk("bp_sym_count", sym_count, 20);

    // Reset mid-batch
    in_i = pack(a_i); in_q = pack(a_q); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("mr_index_before", 32'(out_index), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_sym_count", sym_count, 0);
    chk("mr_out_index", 32'(out_index), 0);
    step();
    chk("mr_no_leftover", 32'(out_valid), 0);
    in_i = pack(b_i); in_q = pack(b_q); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mr_new_valid", 32'(out_valid), 1);
      chk("mr_new_i", 32'(out_i), 32'(b_i[k]));
      chk("mr_new_index", 32'(out_index), 32'(k));
      step();
    end
    chk("mr_sym_count_after", sym_count, 4);

    // 4-bit counter wrap
    w_in_i = pack(a_i); w_in_q = pack(a_q); w_in_valid = 1'b1; w_out_ready = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      chk("wrap_stream_valid", 32'(w_out_valid), 1);
      chk("wrap_stream_i", 32'(w_out_i), 32'(a_i[k % 4]));
      step();
    end
    chk("wrap_count_15", 32'(w_sym_count), 15);
    w_in_valid = 1'b0;
    step();
    chk("wrap_count_0", 32'(w_sym_count), 0);
    chk("wrap_done_valid", 32'(w_out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qam_symbol_serializer.md
Name: qam_symbol_serializer

Overview:
- Sits directly downstream of the parallel QAM-16 mapper.
- Accepts one batch of NUM_SYMBOLS parallel I/Q symbols, i.e. one mapped input word, through a valid/ready handshake.
- Emits the batch one I/Q pair per cycle on a streaming valid/ready output, with a last flag per batch.
- Feeds the pulse-shaping/DAC interface stage and absorbs backpressure from it.

Parameters:
- NUM_SYMBOLS, 4, symbols per batch (mapper INPUT_DATA_WIDTH >> 2); must be >= 2.
- DATA_WIDTH_I, 16, width of each signed I sample.
- DATA_WIDTH_Q, 16, width of each signed Q sample.
- COUNT_WIDTH, 32, width of the emitted-symbol counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  batch on in_i/in_q is valid.
- in_ready  output  1  block accepts batch this cycle.
- in_i  input  NUM_SYMBOLS*DATA_WIDTH_I  flattened I batch; symbol k at [k*DATA_WIDTH_I +: DATA_WIDTH_I].
- in_q  input  NUM_SYMBOLS*DATA_WIDTH_Q  flattened Q batch, same packing.
- out_valid  output  1  out_i/out_q hold a symbol.
- out_ready  input  1  downstream accepts symbol.
- out_i  output  DATA_WIDTH_I  signed I sample.
- out_q  output  DATA_WIDTH_Q  signed Q sample.
- out_last  output  1  high with the final symbol (index NUM_SYMBOLS-1) of a batch.
- out_index  output  $clog2(NUM_SYMBOLS)  symbol index within the current batch.
- sym_count  output  COUNT_WIDTH  total symbols transferred out since reset; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - out_valid=0, out_i=0, out_q=0, out_last=0, out_index=0, sym_count=0.
  - State=IDLE; holding register cleared.
  - in_ready is low while rst is high.
  - Reset mid-batch discards the remaining symbols; none are emitted after reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_valid and out_ready may toggle freely.
  - While out_valid=1 and out_ready=0, out_i, out_q, out_last and out_index hold stable.
- States: IDLE, SEND.
- IDLE:
  - out_valid=0, in_ready=1.
  - On input transfer: latch the whole batch into the holding register, go to SEND, present symbol 0 next cycle.
  - Latency from input accept to first out_valid is 1 cycle.
- SEND:
  - out_valid=1; outputs are driven from registers, never combinationally from in_*.
  - On output transfer with index < NUM_SYMBOLS-1: index+1, present the next symbol the following cycle.
- SEND, last symbol transferred:
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational, from out_ready.
  - If in_valid is high in that cycle: the new batch is latched and its symbol 0 appears the next cycle. Back-to-back batches therefore run with no bubble, sustaining 1 symbol/cycle.
  - Otherwise return to IDLE.
- An input batch is never accepted while an un-emitted symbol of the previous batch remains.
- sym_count increments by 1 on every output transfer and wraps from all-ones to 0.
- Symbol values pass through bit-exact; no scaling or sign manipulation.

Decomposition:
- Shared package qam_pkg holds:
  - state enum typedef (IDLE, SEND);
  - QAM16 bits-per-symbol constant (4);
  - default sample widths;
  - a function computing the index width from NUM_SYMBOLS.
- No sub-module; a single module with a holding register, index counter and FSM is natural.

Test Plan:
- Reset, then in_valid=1 with I batch {s3..s0}={0x7A1E,0x287A,0xD786,0x8702}, same values on Q, out_ready=1:
  - out_valid rises 1 cycle later;
  - out_i = 0x8702, 0xD786, 0x287A, 0x7A1E on consecutive cycles;
  - out_last only on the 4th; out_index 0..3; sym_count=4.
- Two batches back-to-back with in_valid held high and out_ready=1:
  - 8 consecutive output cycles with no gap;
  - in_ready high only on cycles where out_last transfers (plus the initial IDLE cycle).
- out_ready held low for 5 cycles on symbol 2:
  - out_i/out_q/out_index stay at symbol 2 values throughout;
  - in_ready=0;
  - the sequence resumes unchanged when out_ready returns to 1.
- rst asserted while out_index=1:
  - next cycle out_valid=0 and sym_count=0;
  - the following batch starts at out_index 0 with its own symbol 0.
- sym_count preloaded near wrap (COUNT_WIDTH=4 build, 15 symbols emitted), then one more transfer -> sym_count=0.
- in_valid=1 while in SEND mid-batch -> in_ready=0, and the new batch is not latched until the last-symbol transfer cycle.
